mem_unit: RTL and testbench
===========================

# mem_unit

Memory-stage unit of the CPU pipeline, sitting directly after the execute stage and consuming its results. Performs loads, stores and stack accesses against data memory over a req/ack handshake, stalls the pipeline while an access is outstanding, and registers the result into the MEM/WB boundary for writeback. Non-memory instructions pass through with one cycle of latency.

## Interface
- ADDR_W, 16, data-memory word-address width; dmem_addr = selected address[ADDR_W-1:0]
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with MEM_UNIT_TIMEOUT_EN)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute stage presents an instruction this cycle
- RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, MemSrc_in, pop_in  in  1 each  control from execute stage
- DestReg_in  in  5  destination register (0x1B = SP for call/ret)
- EX_in  in  32  execute result (address or writeback value)
- MemWrite_data_in  in  32  store data
- SP_in  in  32  current stack pointer value
- mem_stall  out  1  hold execute stage and earlier
- dmem_req, dmem_we  out  1 each  memory request / write enable
- dmem_addr  out  ADDR_W  memory address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  memory completes current request
- dmem_rdata  in  32  load data, valid with dmem_ack
- wb_valid, RegWrite_out, MemToReg_out, pop_out  out  1 each  MEM/WB control
- DestReg_out  out  5  MEM/WB destination
- WB_data  out  32  writeback value
- mem_err  out  1  sticky timeout flag (only with MEM_UNIT_TIMEOUT_EN; otherwise tied 0)

## Operation
- States: IDLE, REQ, (ABORT with macro).
- IDLE, ex_valid=0: wb_valid<=0.
- IDLE, ex_valid=1, MemRead_in=MemWrite_in=0: MEM/WB registers load inputs, WB_data<=EX_in, wb_valid<=1; stay IDLE.
- IDLE, ex_valid=1, MemRead_in|MemWrite_in: latch all inputs; address = MemSrc_in ? SP_in : EX_in; dmem_we<=MemWrite_in (write wins if both set); dmem_req<=1; go REQ; wb_valid<=0.
- REQ: dmem_req, dmem_we, dmem_addr, dmem_wdata held constant until ack. On dmem_ack: dmem_req<=0; MEM/WB loaded from latch; WB_data<= (MemToReg & ~we) ? dmem_rdata : latched EX_in; wb_valid<=1; go IDLE.
- mem_stall = (state != IDLE); combinational from state only, never from ex_valid.
- dmem_ack in IDLE ignored. ex_valid while mem_stall ignored; upstream holds its inputs.
- pop_in, RegWrite_in, MemToReg_in, DestReg_in passed unchanged to MEM/WB.

## Timing
- Reset: all outputs 0, state IDLE, latch cleared. Reset mid-REQ drops dmem_req immediately; transaction discarded, no wb_valid.
- Non-memory: accepted edge N, wb_valid high for cycle N+1 (exactly one cycle per instruction).
- Memory: accepted edge N, dmem_req high from cycle N+1; ack sampled at edge M; wb_valid high cycle M+1, state IDLE and mem_stall low in cycle M+1; new instruction accepted edge M+1.
- Zero-wait memory (ack in first REQ cycle): load-to-wb_valid = 2 cycles, one stall cycle.
- wb_valid is a single-cycle pulse; MEM/WB data holds until next load.

## Configuration
- MEM_UNIT_TIMEOUT_EN defined: 8-bit-or-wider counter cleared on entering REQ, increments each REQ cycle; reaching TIMEOUT_CYCLES without ack → dmem_req<=0, mem_err<=1 (sticky until reset), state ABORT for one cycle, no wb_valid, then IDLE. Late ack after abort ignored.
- Undefined: no counter, REQ waits indefinitely, mem_err constant 0.

## Structure
- Shared package mem_pkg: state enum (IDLE, REQ, ABORT), SP_REG = 5'h1B, DATA_W = 32.
- One sub-module mem_wb_reg: the MEM/WB pipeline register (async active-low reset, load enable, wb_valid pulse generation). FSM, request latch and watchdog stay in mem_unit.

## Test plan
- Pass-through: ex_valid=1, RegWrite=1, DestReg=5, EX_in=0x1234 → next cycle wb_valid=1, WB_data=0x1234, DestReg_out=5, dmem_req never asserted.
- Load, 3-cycle ack: MemRead=1, MemToReg=1, EX_in=0x40, rdata=0xDEADBEEF → dmem_addr=0x40, mem_stall high 3 cycles, WB_data=0xDEADBEEF one cycle after ack.
- Stack store: MemWrite=1, MemSrc=1, SP_in=0x7F0, data=0x100 → dmem_addr=0x7F0, dmem_we=1, dmem_wdata=0x100; wb WB_data=EX_in.
- Back-to-back: load then ALU op held during stall → ALU op wb_valid exactly one cycle after load's wb_valid; no lost/duplicated pulses.
- Reset during REQ: rst_n low mid-request → dmem_req=0 same cycle, all outputs 0, no wb_valid after release.
- With MEM_UNIT_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → dmem_req falls after 4 REQ cycles, mem_err=1, no wb_valid; later ack ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory stage
// Contents: FSM state enum, stack-pointer register index, datapath width.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ABORT = 2'd2
    } mem_state_t;

    localparam logic [4:0] SP_REG = 5'h1B;
    localparam int         DATA_W = 32;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with single-cycle valid pulse
// Ports: clk, rst_n (async active-low); load strobes the *_in values into the
// register and raises wb_valid for exactly the following cycle; data outputs
// hold until the next load.
module mem_wb_reg
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic              pop_in,
    input  logic [4:0]        dest_reg_in,
    input  logic [DATA_W-1:0] wb_data_in,
    output logic              wb_valid,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic              pop,
    output logic [4:0]        dest_reg,
    output logic [DATA_W-1:0] wb_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            reg_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            pop        <= 1'b0;
            dest_reg   <= 5'd0;
            wb_data    <= '0;
        end else begin
            wb_valid <= load;
            if (load) begin
                reg_write  <= reg_write_in;
                mem_to_reg <= mem_to_reg_in;
                pop        <= pop_in;
                dest_reg   <= dest_reg_in;
                wb_data    <= wb_data_in;
            end
        end
    end

endmodule

// File: rtl/mem_unit.sv
// rtl/mem_unit.sv - pipeline memory stage: load/store/stack access over req/ack
// Ports: clk, rst_n (async active-low); ex_* / *_in from execute stage;
// mem_stall back-pressure; dmem_* memory request channel; MEM/WB outputs
// (wb_valid, RegWrite_out, MemToReg_out, pop_out, DestReg_out, WB_data);
// mem_err sticky watchdog flag.
// Optional feature: MEM_UNIT_TIMEOUT_EN enables the REQ watchdog and ABORT state.
module mem_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              RegWrite_in,
    input  logic              MemWrite_in,
    input  logic              MemRead_in,
    input  logic              MemToReg_in,
    input  logic              MemSrc_in,
    input  logic              pop_in,
    input  logic [4:0]        DestReg_in,
    input  logic [DATA_W-1:0] EX_in,
    input  logic [DATA_W-1:0] MemWrite_data_in,
    input  logic [DATA_W-1:0] SP_in,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              RegWrite_out,
    output logic              MemToReg_out,
    output logic              pop_out,
    output logic [4:0]        DestReg_out,
    output logic [DATA_W-1:0] WB_data,
    output logic              mem_err
);

    mem_state_t state, next_state;

    logic              accept_alu, accept_mem, ack_done, timeout;
    logic [DATA_W-1:0] sel_addr;
    logic              lat_reg_write, lat_mem_to_reg, lat_pop;
    logic [4:0]        lat_dest;
    logic [DATA_W-1:0] lat_ex;

    logic              wb_load, wb_reg_write, wb_mem_to_reg, wb_pop;
    logic [4:0]        wb_dest;
    logic [DATA_W-1:0] wb_data_sel;

    // ex_valid is only honoured in IDLE; upstream holds its inputs while stalled.
    assign accept_alu = (state == IDLE) && ex_valid && !(MemRead_in || MemWrite_in);
    assign accept_mem = (state == IDLE) && ex_valid &&  (MemRead_in || MemWrite_in);
    assign ack_done   = (state == REQ) && dmem_ack;
    assign sel_addr   = MemSrc_in ? SP_in : EX_in;
    assign mem_stall  = (state != IDLE);

    // Only the low ADDR_W bits of the selected address reach memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^sel_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept_mem) next_state = REQ;
            REQ:     if (dmem_ack)     next_state = IDLE;
                     else if (timeout) next_state = ABORT;
            ABORT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request channel and instruction latch; dmem_we doubles as the latched
    // write flag, so a store never selects read data for writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            lat_reg_write  <= 1'b0;
            lat_mem_to_reg <= 1'b0;
            lat_pop        <= 1'b0;
            lat_dest       <= 5'd0;
            lat_ex         <= '0;
        end else if (accept_mem) begin
            dmem_req       <= 1'b1;
            dmem_we        <= MemWrite_in;
            dmem_addr      <= sel_addr[ADDR_W-1:0];
            dmem_wdata     <= MemWrite_data_in;
            lat_reg_write  <= RegWrite_in;
            lat_mem_to_reg <= MemToReg_in;
            lat_pop        <= pop_in;
            lat_dest       <= DestReg_in;
            lat_ex         <= EX_in;
        end else if (ack_done || timeout) begin
            dmem_req <= 1'b0;
        end
    end

`ifdef MEM_UNIT_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wd_cnt;

    // Fires in the REQ cycle that would make the count reach TIMEOUT_CYCLES.
    assign timeout = (state == REQ) && !dmem_ack &&
                     (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            mem_err <= 1'b0;
        end else begin
            if (accept_mem)          wd_cnt <= '0;
            else if (state == REQ)   wd_cnt <= wd_cnt + 1'b1;
            if (timeout)             mem_err <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    // Pass-through ops load straight from the inputs; memory ops load from the latch.
    assign wb_load       = accept_alu || ack_done;
    assign wb_reg_write  = accept_alu ? RegWrite_in : lat_reg_write;
    assign wb_mem_to_reg = accept_alu ? MemToReg_in : lat_mem_to_reg;
    assign wb_pop        = accept_alu ? pop_in      : lat_pop;
    assign wb_dest       = accept_alu ? DestReg_in  : lat_dest;
    assign wb_data_sel   = accept_alu ? EX_in :
                           (lat_mem_to_reg && !dmem_we) ? dmem_rdata : lat_ex;

    mem_wb_reg u_mem_wb_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (wb_load),
        .reg_write_in  (wb_reg_write),
        .mem_to_reg_in (wb_mem_to_reg),
        .pop_in        (wb_pop),
        .dest_reg_in   (wb_dest),
        .wb_data_in    (wb_data_sel),
        .wb_valid      (wb_valid),
        .reg_write     (RegWrite_out),
        .mem_to_reg    (MemToReg_out),
        .pop           (pop_out),
        .dest_reg      (DestReg_out),
        .wb_data       (WB_data)
    );

endmodule

// File: tb/tb_mem_unit.sv
// tb/tb_mem_unit.sv - directed self-checking bench for mem_unit
module tb_mem_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, MemSrc_in, pop_in;
    logic [4:0]  DestReg_in;
    logic [31:0] EX_in, MemWrite_data_in, SP_in;
    logic        mem_stall, dmem_req, dmem_we;
    logic [15:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid, RegWrite_out, MemToReg_out, pop_out;
    logic [4:0]  DestReg_out;
    logic [31:0] WB_data;
    logic        mem_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_unit #(.ADDR_W(16), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
        .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
        .MemToReg_in(MemToReg_in), .MemSrc_in(MemSrc_in), .pop_in(pop_in),
        .DestReg_in(DestReg_in), .EX_in(EX_in), .MemWrite_data_in(MemWrite_data_in),
        .SP_in(SP_in), .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .RegWrite_out(RegWrite_out),
        .MemToReg_out(MemToReg_out), .pop_out(pop_out), .DestReg_out(DestReg_out),
        .WB_data(WB_data), .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid = 0; RegWrite_in = 0; MemWrite_in = 0; MemRead_in = 0;
        MemToReg_in = 0; MemSrc_in = 0; pop_in = 0; DestReg_in = 0;
        EX_in = 0; MemWrite_data_in = 0; SP_in = 0;
    endtask

    initial begin
        rst_n = 0; dmem_ack = 0; dmem_rdata = 0;
        clear_inputs();
        step(); step();
        chk("rst_wb_valid", {31'd0, wb_valid}, 0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 0);
        chk("rst_stall", {31'd0, mem_stall}, 0);
        chk("rst_wb_data", WB_data, 0);
        chk("rst_addr", {16'd0, dmem_addr}, 0);
        chk("rst_mem_err", {31'd0, mem_err}, 0);
        rst_n = 1;
        step();

        // Pass-through ALU op
        ex_valid = 1; RegWrite_in = 1; DestReg_in = 5'd5; EX_in = 32'h1234;
        step();
        clear_inputs();
        chk("pt_wb_valid", {31'd0, wb_valid}, 1);
        chk("pt_wb_data", WB_data, 32'h1234);
        chk("pt_dest", {27'd0, DestReg_out}, 5);
        chk("pt_regwrite", {31'd0, RegWrite_out}, 1);
        chk("pt_no_req", {31'd0, dmem_req}, 0);
        chk("pt_no_stall", {31'd0, mem_stall}, 0);
        step();
        chk("pt_pulse_end", {31'd0, wb_valid}, 0);
        chk("pt_data_hold", WB_data, 32'h1234);

        // Load with ack in the third REQ cycle
        ex_valid = 1; MemRead_in = 1; MemToReg_in = 1; RegWrite_in = 1;
        DestReg_in = 5'd7; EX_in = 32'h40;
        step();
        clear_inputs();
        chk("ld_req1", {31'd0, dmem_req}, 1);
        chk("ld_addr", {16'd0, dmem_addr}, 32'h40);
        chk("ld_we", {31'd0, dmem_we}, 0);
        chk("ld_stall1", {31'd0, mem_stall}, 1);
        chk("ld_wbv1", {31'd0, wb_valid}, 0);
        step();
        chk("ld_stall2", {31'd0, mem_stall}, 1);
        chk("ld_req2", {31'd0, dmem_req}, 1);
        step();
        chk("ld_stall3", {31'd0, mem_stall}, 1);
        dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
        step();
        dmem_ack = 0; dmem_rdata = 32'h0;
        chk("ld_wb_valid", {31'd0, wb_valid}, 1);
        chk("ld_wb_data", WB_data, 32'hDEADBEEF);
        chk("ld_dest", {27'd0, DestReg_out}, 7);
        chk("ld_memtoreg", {31'd0, MemToReg_out}, 1);
        chk("ld_stall_low", {31'd0, mem_stall}, 0);
        chk("ld_req_low", {31'd0, dmem_req}, 0);
        step();
        chk("ld_pulse_end", {31'd0, wb_valid}, 0);
        chk("ld_data_hold", WB_data, 32'hDEADBEEF);

        // Stray ack while idle
        dmem_ack = 1;
        step();
        dmem_ack = 0;
        chk("idle_ack_wbv", {31'd0, wb_valid}, 0);
        chk("idle_ack_stall", {31'd0, mem_stall}, 0);

        // Stack store, zero-wait ack; write wins over read, WB takes EX_in
        ex_valid = 1; MemWrite_in = 1; MemRead_in = 1; MemSrc_in = 1; MemToReg_in = 1;
        RegWrite_in = 1; DestReg_in = 5'h1B; SP_in = 32'h7F0;
        MemWrite_data_in = 32'h100; EX_in = 32'h55;
        step();
        clear_inputs();
        EX_in = 32'h99;
        chk("st_addr", {16'd0, dmem_addr}, 32'h7F0);
        chk("st_we", {31'd0, dmem_we}, 1);
        chk("st_wdata", dmem_wdata, 32'h100);
        chk("st_req", {31'd0, dmem_req}, 1);
        dmem_ack = 1; dmem_rdata = 32'hBAD;
        step();
        dmem_ack = 0; EX_in = 0;
        chk("st_wb_valid", {31'd0, wb_valid}, 1);
        chk("st_wb_data", WB_data, 32'h55);
        chk("st_dest", {27'd0, DestReg_out}, 32'h1B);
        chk("st_stall_low", {31'd0, mem_stall}, 0);

        // Back-to-back: load then ALU op held through the stall
        ex_valid = 1; MemRead_in = 1; MemToReg_in = 1; RegWrite_in = 1;
        DestReg_in = 5'd3; EX_in = 32'h80;
        step();
        clear_inputs();
        ex_valid = 1; RegWrite_in = 1; pop_in = 1; DestReg_in = 5'd4; EX_in = 32'hA1;
        dmem_ack = 1; dmem_rdata = 32'h1111;
        chk("bb_stall", {31'd0, mem_stall}, 1);
        chk("bb_wbv0", {31'd0, wb_valid}, 0);
        step();
        dmem_ack = 0;
        chk("bb_ld_wbv", {31'd0, wb_valid}, 1);
        chk("bb_ld_data", WB_data, 32'h1111);
        chk("bb_ld_dest", {27'd0, DestReg_out}, 3);
        chk("bb_ld_pop", {31'd0, pop_out}, 0);
        step();
        clear_inputs();
        chk("bb_alu_wbv", {31'd0, wb_valid}, 1);
        chk("bb_alu_data", WB_data, 32'hA1);
        chk("bb_alu_dest", {27'd0, DestReg_out}, 4);
        chk("bb_alu_pop", {31'd0, pop_out}, 1);
        step();
        chk("bb_no_dup", {31'd0, wb_valid}, 0);
        chk("bb_no_req", {31'd0, dmem_req}, 0);

        // Reset in the middle of a request
        ex_valid = 1; MemRead_in = 1; MemToReg_in = 1; RegWrite_in = 1;
        DestReg_in = 5'd9; EX_in = 32'hC0;
        step();
        clear_inputs();
        chk("rr_req", {31'd0, dmem_req}, 1);
        #2 rst_n = 0;
        #1;
        chk("rr_req_drop", {31'd0, dmem_req}, 0);
        chk("rr_stall", {31'd0, mem_stall}, 0);
        chk("rr_wb_data", WB_data, 0);
        chk("rr_dest", {27'd0, DestReg_out}, 0);
        step();
        rst_n = 1;
        dmem_ack = 1; dmem_rdata = 32'h7777;
        step();
        dmem_ack = 0;
        chk("rr_no_wbv", {31'd0, wb_valid}, 0);
        chk("rr_no_stall", {31'd0, mem_stall}, 0);
        step();
        chk("rr_no_wbv2", {31'd0, wb_valid}, 0);

`ifdef MEM_UNIT_TIMEOUT_EN
        // Watchdog: TIMEOUT_CYCLES=4, memory never acks
        ex_valid = 1; MemRead_in = 1; MemToReg_in = 1; DestReg_in = 5'd2; EX_in = 32'h10;
        step();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_req_%0d", i), {31'd0, dmem_req}, 1);
            step();
        end
        chk("to_req_drop", {31'd0, dmem_req}, 0);
        chk("to_mem_err", {31'd0, mem_err}, 1);
        chk("to_abort_stall", {31'd0, mem_stall}, 1);
        chk("to_no_wbv", {31'd0, wb_valid}, 0);
        step();
        chk("to_idle", {31'd0, mem_stall}, 0);
        dmem_ack = 1; dmem_rdata = 32'h5A5A;
        step();
        dmem_ack = 0;
        chk("to_late_ack", {31'd0, wb_valid}, 0);
        chk("to_err_sticky", {31'd0, mem_err}, 1);
`else
        chk("no_to_mem_err", {31'd0, mem_err}, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
